// File: rtl/mil_tx_queue.sv
// MIL-STD-1553B word transmitter fed by a small word FIFO; queued words are sent back-to-back.
// Optional build macro MIL_TX_PARITY_INJECT_EN adds iBAD_PAR to invert a word's parity bit.
module mil_tx_queue #(
   parameter int HALF_BIT_CLKS = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int LVL_W         = 3
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iWR,
   input  logic             iCD,
   input  logic [15:0]      iDATA,
`ifdef MIL_TX_PARITY_INJECT_EN
   input  logic             iBAD_PAR,
`endif
   input  logic             iABORT,
   output logic             oFULL,
   output logic [LVL_W-1:0] oLEVEL,
   output logic             oOVF,
   output logic [1:0]       oDO,
   output logic             oBUSY,
   output logic             oDONE
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_BIT_CLKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

`ifdef MIL_TX_PARITY_INJECT_EN
   localparam int ENTRY_W = 18;
   logic [ENTRY_W-1:0] wr_entry;
   assign wr_entry = {iBAD_PAR, iCD, iDATA};
`else
   localparam int ENTRY_W = 17;
   logic [ENTRY_W-1:0] wr_entry;
   assign wr_entry = {iCD, iDATA};
`endif

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   count_q;
   logic               ovf_q;
   logic               full, empty, push, pop;

   // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
   assign full  = (count_q == DEPTH_L);
   assign empty = (count_q == '0);
   assign push  = iWR & ~full & ~iABORT;

   always_ff @(posedge iCLK) begin
      if (push)
         mem_q[wr_ptr_q] <= wr_entry;
   end

   always_ff @(posedge iCLK) begin
      if (iRESET || iABORT) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ovf_q <= iWR & full;
         if (push)
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !pop)
            count_q <= count_q + LVL_ONE;
         else if (!push && pop)
            count_q <= count_q - LVL_ONE;
      end
   end

   // Head word expanded to 40 half-bit levels, earliest symbol in bit 39.
   logic [ENTRY_W-1:0] head;
   logic               head_par;
   logic [39:0]        head_syms;

   assign head = mem_q[rd_ptr_q];
`ifdef MIL_TX_PARITY_INJECT_EN
   assign head_par = ~(^head[15:0]) ^ head[17];
`else
   assign head_par = ~(^head[15:0]);
`endif
   assign head_syms[39:34] = head[16] ? 6'b111000 : 6'b000111;
   assign head_syms[1:0]   = head_par ? 2'b10 : 2'b01;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_enc
         assign head_syms[2*gi+2 +: 2] = head[gi] ? 2'b10 : 2'b01;
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q;
   logic [38:0]      sr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [5:0]       idx_q;
   logic [1:0]       do_q;
   logic             busy_q, done_q;
   logic             last_sym, end_of_word;

   assign last_sym    = (idx_q == 6'd39);
   assign end_of_word = (state_q == SEND) && last_sym && (cnt_q == CNT_MAX);
   assign pop         = ~iABORT & ~empty & ((state_q == IDLE) | end_of_word);

   // do_q carries the current symbol; sr_q holds the symbols still to come.
   always_ff @(posedge iCLK) begin
      if (iRESET || iABORT) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         do_q    <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (pop) begin
            state_q <= SEND;
            sr_q    <= head_syms[38:0];
            cnt_q   <= '0;
            idx_q   <= '0;
            do_q    <= {head_syms[39], ~head_syms[39]};
            busy_q  <= 1'b1;
         end else if (state_q == SEND) begin
            if (cnt_q != CNT_MAX) begin
               cnt_q  <= cnt_q + CNT_ONE;
               done_q <= last_sym && ((cnt_q + CNT_ONE) == CNT_MAX);
            end else if (!last_sym) begin
               cnt_q  <= '0;
               idx_q  <= idx_q + 6'd1;
               sr_q   <= {sr_q[37:0], 1'b0};
               do_q   <= {sr_q[38], ~sr_q[38]};
               done_q <= (idx_q == 6'd38) && (CNT_MAX == '0);
            end else begin
               state_q <= IDLE;
               sr_q    <= '0;
               cnt_q   <= '0;
               idx_q   <= '0;
               do_q    <= 2'b00;
               busy_q  <= 1'b0;
            end
         end
      end
   end

   assign oFULL  = full;
   assign oLEVEL = count_q;
   assign oOVF   = ovf_q;
   assign oDO    = do_q;
   assign oBUSY  = busy_q;
   assign oDONE  = done_q;
endmodule

// File: tb/tb_mil_tx_queue.sv
// Randomised self-checking bench for mil_tx_queue against a queue-based line model.
// Build with MIL_TX_PARITY_INJECT_EN defined to also exercise parity injection.
`timescale 1ns/1ps
module tb_mil_tx_queue;
   localparam int H        = 4;
   localparam int DEPTH    = 4;
   localparam int LVL_W    = 3;
   localparam int WORD_CYC = 40 * H;
`ifdef MIL_TX_PARITY_INJECT_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   logic             clk   = 1'b0;
   logic             rst   = 1'b0;
   logic             wr    = 1'b0;
   logic             cd    = 1'b0;
   logic             bad   = 1'b0;
   logic             abort = 1'b0;
   logic [15:0]      data  = '0;
   logic             oFULL, oOVF, oBUSY, oDONE;
   logic [LVL_W-1:0] oLEVEL;
   logic [1:0]       oDO;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   always #5 clk = ~clk;

   mil_tx_queue #(
      .HALF_BIT_CLKS(H),
      .FIFO_DEPTH   (DEPTH),
      .LVL_W        (LVL_W)
   ) dut (
      .iCLK    (clk),
      .iRESET  (rst),
      .iWR     (wr),
      .iCD     (cd),
      .iDATA   (data),
`ifdef MIL_TX_PARITY_INJECT_EN
      .iBAD_PAR(bad),
`endif
      .iABORT  (abort),
      .oFULL   (oFULL),
      .oLEVEL  (oLEVEL),
      .oOVF    (oOVF),
      .oDO     (oDO),
      .oBUSY   (oBUSY),
      .oDONE   (oDONE)
   );

   // Line model: a queue of stored words plus the elapsed cycle count within the word on the wire.
   logic [17:0] m_fifo[$];
   logic [17:0] m_cur = '0;
   int          m_el  = -1;
   logic [8:0]  e_vec = '0;

   function automatic logic sym_level(input logic [17:0] w, input int k);
      int   bi;
      logic b;
      logic p;
      if (k < 6)
         return w[16] ? (k < 3) : (k >= 3);
      if (k < 38) begin
         bi = 15 - (k - 6) / 2;
         b  = w[bi];
         return (((k - 6) % 2) == 0) ? b : ~b;
      end
      p = ~(^w[15:0]) ^ (INJ & w[17]);
      return (k == 38) ? p : ~p;
   endfunction

   task automatic model_step(input logic w, input logic c, input logic [15:0] d,
                             input logic b, input logic a, input logic r);
      logic       was_full;
      logic       e_ovf;
      logic       e_busy;
      logic       e_done;
      logic [1:0] e_do;
      was_full = (m_fifo.size() == DEPTH);
      e_ovf    = 1'b0;
      if (r || a) begin
         m_fifo.delete();
         m_el = -1;
      end else begin
         e_ovf = w && was_full;
         if (m_el < 0 || m_el == WORD_CYC - 1) begin
            if (m_fifo.size() > 0) begin
               m_cur = m_fifo.pop_front();
               m_el  = 0;
            end else begin
               m_el = -1;
            end
         end else begin
            m_el++;
         end
         if (w && !was_full)
            m_fifo.push_back({b, c, d});
      end
      e_busy = (m_el >= 0);
      e_done = (m_el == WORD_CYC - 1);
      e_do   = 2'b00;
      if (e_busy)
         e_do = sym_level(m_cur, m_el / H) ? 2'b10 : 2'b01;
      e_vec = {e_busy, e_done, e_ovf, (m_fifo.size() == DEPTH), LVL_W'(m_fifo.size()), e_do};
   endtask

   task automatic tick(input logic w, input logic c, input logic [15:0] d,
                       input logic b, input logic a, input logic r);
      wr = w; cd = c; data = d; bad = b; abort = a; rst = r;
      @(posedge clk);
      model_step(w, c, d, b, a, r);
      #1;
      cyc++;
   endtask

   function automatic logic [8:0] obs();
      return {oBUSY, oDONE, oOVF, oFULL, oLEVEL, oDO};
   endfunction

   task automatic test_reset();
      tick(0, 0, 16'h0, 0, 0, 1);
      tick(0, 0, 16'h0, 0, 0, 1);
      tests_run++;
      if (obs() !== 9'b0) begin
         tests_failed++;
         $display("FAIL reset_state got=%b want=%b", obs(), 9'b0);
      end
      $display("[TB] reset applied, outputs=%b", obs());
   endtask

   task automatic test_single_word();
      int busy_n = 0, done_at = -1, first_busy = -1;
      tick(1, 1, 16'h8001, 0, 0, 0);
      tests_run++;
      if (obs() !== e_vec) begin
         tests_failed++;
         $display("FAIL single_push cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
      end
      for (int i = 1; i <= WORD_CYC + 10; i++) begin
         tick(0, 0, 16'h0, 0, 0, 0);
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL single_cycle i=%0d got=%b want=%b", i, obs(), e_vec);
         end
         if (oBUSY) begin
            busy_n++;
            if (first_busy < 0) first_busy = i;
         end
         if (oDONE) done_at = i;
      end
      tests_run++;
      if (busy_n !== WORD_CYC) begin
         tests_failed++;
         $display("FAIL single_busy_len got=%0d want=%0d", busy_n, WORD_CYC);
      end
      tests_run++;
      if (done_at !== WORD_CYC) begin
         tests_failed++;
         $display("FAIL single_done_pos got=%0d want=%0d", done_at, WORD_CYC);
      end
      tests_run++;
      if (first_busy !== 1) begin
         tests_failed++;
         $display("FAIL single_latency got=%0d want=1", first_busy);
      end
      $display("[TB] single word 8001: busy=%0d done_at=%0d", busy_n, done_at);
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [3] = '{16'h0000, 16'hFFFF, 16'hA5A5};
      logic        cds   [3] = '{1'b1, 1'b0, 1'b0};
      int busy_n = 0, done_n = 0, first_b = -1, last_b = -1;
      int done_c [3] = '{0, 0, 0};
      for (int i = 0; i < 3; i++) begin
         tick(1, cds[i], words[i], 0, 0, 0);
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL b2b_push i=%0d got=%b want=%b", i, obs(), e_vec);
         end
         if (oBUSY) begin busy_n++; if (first_b < 0) first_b = cyc; last_b = cyc; end
      end
      for (int i = 0; i < 3 * WORD_CYC + 10; i++) begin
         tick(0, 0, 16'h0, 0, 0, 0);
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL b2b_cycle cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
         end
         if (oBUSY) begin busy_n++; if (first_b < 0) first_b = cyc; last_b = cyc; end
         if (oDONE) begin
            if (done_n < 3) done_c[done_n] = cyc;
            done_n++;
         end
      end
      tests_run++;
      if (busy_n !== 3 * WORD_CYC || (last_b - first_b + 1) !== 3 * WORD_CYC) begin
         tests_failed++;
         $display("FAIL b2b_contiguous busy=%0d span=%0d want=%0d", busy_n, last_b - first_b + 1, 3 * WORD_CYC);
      end
      tests_run++;
      if (done_n !== 3) begin
         tests_failed++;
         $display("FAIL b2b_done_count got=%0d want=3", done_n);
      end
      tests_run++;
      if ((done_c[1] - done_c[0]) !== WORD_CYC || (done_c[2] - done_c[1]) !== WORD_CYC) begin
         tests_failed++;
         $display("FAIL b2b_done_spacing got=%0d,%0d want=%0d", done_c[1] - done_c[0], done_c[2] - done_c[1], WORD_CYC);
      end
      $display("[TB] back-to-back 3 words: busy=%0d dones=%0d", busy_n, done_n);
   endtask

   task automatic test_overflow();
      int ovf_n = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1, 1'($urandom_range(0, 1)), 16'($urandom), 0, 0, 0);
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL ovf_push i=%0d got=%b want=%b", i, obs(), e_vec);
         end
         if (oOVF) ovf_n++;
      end
      tests_run++;
      if (oLEVEL !== LVL_W'(4) || oFULL !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_full level=%0d full=%b want level=4 full=1", oLEVEL, oFULL);
      end
      for (int i = 0; i < 5 * WORD_CYC + 10; i++) begin
         tick(0, 0, 16'h0, 0, 0, 0);
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL ovf_drain cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
         end
         if (oOVF) ovf_n++;
      end
      tests_run++;
      if (ovf_n !== 1) begin
         tests_failed++;
         $display("FAIL ovf_pulses got=%0d want=1", ovf_n);
      end
      $display("[TB] overflow: ovf pulses=%0d", ovf_n);
   endtask

   task automatic test_abort();
      int busy_n = 0;
      for (int i = 0; i < 3; i++)
         tick(1, 1'(i & 1), 16'($urandom), 0, 0, 0);
      for (int i = 0; i < 48; i++)
         tick(0, 0, 16'h0, 0, 0, 0);
      tick(1, 1, 16'h1234, 0, 1, 0);
      tests_run++;
      if (oDO !== 2'b00 || oBUSY !== 1'b0 || oLEVEL !== '0 || oOVF !== 1'b0 || oDONE !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_state do=%b busy=%b level=%0d ovf=%b done=%b want all 0", oDO, oBUSY, oLEVEL, oOVF, oDONE);
      end
      for (int i = 0; i < 200; i++) begin
         tick(0, 0, 16'h0, 0, 0, 0);
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL abort_after cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
         end
         if (oBUSY || oDONE) busy_n++;
      end
      tests_run++;
      if (busy_n !== 0) begin
         tests_failed++;
         $display("FAIL abort_quiet got=%0d busy cycles want=0", busy_n);
      end
      $display("[TB] abort mid-word: post-abort busy cycles=%0d", busy_n);
   endtask

   task automatic test_reset_midword();
      int first_busy = -1;
      tick(1, 1, 16'hC3C3, 0, 0, 0);
      tick(1, 0, 16'h0F0F, 0, 0, 0);
      for (int i = 0; i < 30; i++)
         tick(0, 0, 16'h0, 0, 0, 0);
      tick(0, 0, 16'h0, 0, 0, 1);
      tests_run++;
      if (obs() !== 9'b0) begin
         tests_failed++;
         $display("FAIL reset_midword got=%b want=%b", obs(), 9'b0);
      end
      tick(1, 0, 16'h5A5A, 0, 0, 0);
      for (int i = 1; i <= WORD_CYC + 5; i++) begin
         tick(0, 0, 16'h0, 0, 0, 0);
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL reset_restart i=%0d got=%b want=%b", i, obs(), e_vec);
         end
         if (oBUSY && first_busy < 0) first_busy = i;
      end
      tests_run++;
      if (first_busy !== 1) begin
         tests_failed++;
         $display("FAIL reset_restart_latency got=%0d want=1", first_busy);
      end
      $display("[TB] reset mid-word then restart: first busy at +%0d", first_busy);
   endtask

   task automatic test_random();
      int rv;
      logic w;
      for (int i = 0; i < 4000; i++) begin
         rv = int'($urandom_range(0, 999));
         w  = ($urandom_range(0, 99) < 6);
         tick(w, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
              (rv >= 2 && rv < 6), (rv < 2));
         tests_run++;
         if (obs() !== e_vec) begin
            tests_failed++;
            $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs(), e_vec);
         end
      end
      $display("[TB] random run of 4000 cycles done");
   endtask

`ifdef MIL_TX_PARITY_INJECT_EN
   task automatic test_parity_inject();
      logic [1:0] s38, s39;
      for (int b = 1; b >= 0; b--) begin
         s38 = 2'b00; s39 = 2'b00;
         tick(1, 1, 16'h0001, 1'(b), 0, 0);
         for (int i = 1; i <= WORD_CYC + 5; i++) begin
            tick(0, 0, 16'h0, 0, 0, 0);
            tests_run++;
            if (obs() !== e_vec) begin
               tests_failed++;
               $display("FAIL parity_cycle bad=%0d i=%0d got=%b want=%b", b, i, obs(), e_vec);
            end
            if (i == 1 + 38 * H) s38 = oDO;
            if (i == 1 + 39 * H) s39 = oDO;
         end
         tests_run++;
         if ({s38, s39} !== ((b == 1) ? 4'b1001 : 4'b0110)) begin
            tests_failed++;
            $display("FAIL parity_symbols bad=%0d got=%b,%b want=%b", b, s38, s39, (b == 1) ? 4'b1001 : 4'b0110);
         end
         $display("[TB] parity inject bad=%0d: symbols %b,%b", b, s38, s39);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_abort();
      test_reset_midword();
`ifdef MIL_TX_PARITY_INJECT_EN
      test_parity_inject();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
